// File: rtl/seven_seg_display_controller.sv
// -----------------------------------------------------------------------------
// seven_seg_display_controller
//
// Front end for a 4-digit multiplexed common-anode 7-segment display.
//   - Accepts a 14-bit binary value over a valid/ready handshake.
//   - Clamps it to 9999, then converts it to four BCD digits with a sequential
//     shift-add-3 (double-dabble) engine, one step per clock (14 steps).
//   - The finished BCD is committed to a separate "shown" register, so the
//     display never shows a partially converted value.
//   - A free-running prescaler time-multiplexes the four digits onto the
//     active-low digit enables and segment lines. The decimal point is lit on
//     digit DP_DIGIT.
//
// Optional feature macro: SEVSEG_BLANK_EN
//   Defined   : leading-zero blanking (never on units or on the DP_DIGIT digit).
//   Undefined : all four digits always show, leading zeros included.
//
// Parameters
//   SCAN_W   prescaler width; digit index = scan[SCAN_W-1:SCAN_W-2]
//   DP_DIGIT digit carrying the decimal point (0 = leftmost .. 3), 4 = none
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   in_value is presented
//   in_value  in   [13:0] binary value to display
//   in_ready  out  controller can accept (FSM idle)
//   busy      out  conversion in progress (FSM not idle)
//   ovf       out  last accepted value exceeded 9999 and was clamped
//   digit     out  [3:0] active-low digit enables, bit3 = leftmost
//   segments  out  [7:0] {p,g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seven_seg_display_controller #(
  parameter int SCAN_W   = 19,
  parameter int DP_DIGIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [13:0] in_value,
  output logic        in_ready,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  digit,
  output logic [7:0]  segments
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [2:0]  DP_POS  = 3'(DP_DIGIT);
  localparam logic [13:0] MAX_VAL = 14'd9999;

  state_t             state_r;
  state_t             state_s;
  logic               accept_s;
  logic [13:0]        bin_r;
  logic [15:0]        scratch_r;
  logic [15:0]        shown_r;
  logic [3:0]         step_r;
  logic [SCAN_W-1:0]  scan_r;
  logic [1:0]         idx_s;
  logic [3:0]         nib_s;
  logic [3:0]         digit_s;
  logic               dp_s;
  logic [7:0]         seg_s;
`ifdef SEVSEG_BLANK_EN
  logic               blank_s;
`endif

  // 7-segment pattern, active-high pgfedcba without the point; illegal -> "0"
  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'd0:    code = 7'h3F;
      4'd1:    code = 7'h06;
      4'd2:    code = 7'h5B;
      4'd3:    code = 7'h4F;
      4'd4:    code = 7'h66;
      4'd5:    code = 7'h6D;
      4'd6:    code = 7'h7D;
      4'd7:    code = 7'h07;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h6F;
      default: code = 7'h3F;
    endcase
    return code;
  endfunction

  // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left
  function automatic logic [29:0] dd_step(input logic [15:0] bcd, input logic [13:0] bin);
    logic [15:0] adj;
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = adj[4*i +: 4];
      end
    end
    return {adj[14:0], bin, 1'b0};
  endfunction

  // Next-state logic for the IDLE -> CONV -> COMMIT sequence
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s  = CONV;
          accept_s = 1'b1;
        end else begin
          state_s  = IDLE;
        end
      end
      CONV: begin
        if (step_r == 4'd0) begin
          state_s = COMMIT;
        end else begin
          state_s = CONV;
        end
      end
      COMMIT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register; handshake flags are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      in_ready <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state_r  <= state_s;
      in_ready <= (state_s == IDLE);
      busy     <= (state_s != IDLE);
    end
  end

  // Conversion datapath: latch/clamp, iterate, commit to the shown buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r     <= 14'd0;
      scratch_r <= 16'd0;
      step_r    <= 4'd0;
      shown_r   <= 16'd0;
      ovf       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            bin_r     <= (in_value > MAX_VAL) ? MAX_VAL : in_value;
            scratch_r <= 16'd0;
            step_r    <= 4'd13;
            ovf       <= (in_value > MAX_VAL);
          end else begin
            step_r    <= step_r;
          end
        end
        CONV: begin
          {scratch_r, bin_r} <= dd_step(scratch_r, bin_r);
          if (step_r != 4'd0) begin
            step_r <= step_r - 4'd1;
          end else begin
            step_r <= step_r;
          end
        end
        COMMIT:  shown_r <= scratch_r;
        default: step_r  <= 4'd0;
      endcase
    end
  end

  // Free-running scan prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_r <= '0;
    end else begin
      scan_r <= scan_r + {{(SCAN_W-1){1'b0}}, 1'b1};
    end
  end

  assign idx_s = scan_r[SCAN_W-1 -: 2];

  // Digit select, segment pattern, decimal point and optional blanking
  always_comb begin
    digit_s = 4'b1111;
    nib_s   = 4'd0;
`ifdef SEVSEG_BLANK_EN
    blank_s = 1'b0;
`endif
    case (idx_s)
      2'd0: begin
        digit_s = 4'b0111;
        nib_s   = shown_r[15:12];
`ifdef SEVSEG_BLANK_EN
        blank_s = (shown_r[15:12] == 4'd0);
`endif
      end
      2'd1: begin
        digit_s = 4'b1011;
        nib_s   = shown_r[11:8];
`ifdef SEVSEG_BLANK_EN
        blank_s = (shown_r[15:8] == 8'd0);
`endif
      end
      2'd2: begin
        digit_s = 4'b1101;
        nib_s   = shown_r[7:4];
`ifdef SEVSEG_BLANK_EN
        blank_s = (shown_r[15:4] == 12'd0);
`endif
      end
      2'd3: begin
        digit_s = 4'b1110;
        nib_s   = shown_r[3:0];
      end
      default: begin
        digit_s = 4'b1111;
        nib_s   = 4'd0;
      end
    endcase
    if ({1'b0, idx_s} == DP_POS) begin
      dp_s = 1'b0;
    end else begin
      dp_s = 1'b1;
    end
`ifdef SEVSEG_BLANK_EN
    // Only digits left of the decimal point may blank; units never does
    if (blank_s && ({1'b0, idx_s} < DP_POS)) begin
      seg_s = 8'hFF;
    end else begin
      seg_s = {dp_s, ~seg_code(nib_s)};
    end
`else
    seg_s = {dp_s, ~seg_code(nib_s)};
`endif
  end

  // Registered pin drivers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit    <= 4'b1111;
      segments <= 8'hFF;
    end else begin
      digit    <= digit_s;
      segments <= seg_s;
    end
  end

endmodule
